// File: rtl/memory_responder.sv
// memory_responder: memory-side Cache2Memory endpoint serving line fills and absorbing writebacks
module memory_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int OFFSET_BITS    = 3,
  parameter int ADDRESS_BITS   = 20,
  parameter int MSG_BITS       = 4,
  parameter int MEM_DEPTH_BITS = 12,
  parameter int LATENCY        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     cache2mem_msg,
  input  logic [ADDRESS_BITS-1:0] cache2mem_address,
  input  logic [DATA_WIDTH-1:0]   cache2mem_data,
  output logic [MSG_BITS-1:0]     mem2cache_msg,
  output logic [ADDRESS_BITS-1:0] mem2cache_address,
  output logic [DATA_WIDTH-1:0]   mem2cache_data,
  output logic                    busy,
  input  logic                    report
);
  localparam int N = 1 << OFFSET_BITS;
  localparam int WW = LATENCY > 2 ? $clog2(LATENCY - 1) : 1;
  localparam int WAIT_INIT = LATENCY > 1 ? LATENCY - 2 : 0;
  localparam logic [MSG_BITS-1:0] NO_REQ = 0, R_REQ = 1, WB_REQ = 2, MEM_SENT = 3, MEM_READY = 4;
  typedef enum logic [2:0] {IDLE, READ_WAIT, READ_SEND, WRITE_RECV, WRITE_ACK} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] ram [0:(1<<MEM_DEPTH_BITS)-1];
  logic [ADDRESS_BITS-1:0] base, last_addr, rd_addr;
  logic [OFFSET_BITS:0] idx;
  logic [WW-1:0] wait_cnt;
  logic [31:0] read_bursts, write_bursts, cycles;
  logic we;
  assign we = !reset && cache2mem_msg == WB_REQ && (state == IDLE || state == WRITE_RECV);
  assign rd_addr = base + ADDRESS_BITS'(idx);
  // writeback words land in RAM the edge they are sampled; RAM survives reset
  always_ff @(posedge clock)
    if (we) ram[cache2mem_address[MEM_DEPTH_BITS-1:0]] <= cache2mem_data;
  // request FSM with registered response outputs and burst/cycle counters
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      mem2cache_msg <= NO_REQ;
      mem2cache_address <= '0;
      mem2cache_data <= '0;
      idx <= '0;
      wait_cnt <= '0;
      base <= '0;
      last_addr <= '0;
      read_bursts <= '0;
      write_bursts <= '0;
      cycles <= '0;
    end else begin
      cycles <= cycles + 1;
      mem2cache_msg <= NO_REQ;
      mem2cache_address <= '0;
      mem2cache_data <= '0;
      case (state)
        IDLE:
          if (cache2mem_msg == R_REQ) begin
            base <= {cache2mem_address[ADDRESS_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
            idx <= '0;
            wait_cnt <= WW'(WAIT_INIT);
            state <= LATENCY == 1 ? READ_SEND : READ_WAIT;
            busy <= 1'b1;
            read_bursts <= read_bursts + 1;
          end else if (cache2mem_msg == WB_REQ) begin
            last_addr <= cache2mem_address;
            idx <= (OFFSET_BITS+1)'(1);
            state <= N == 1 ? WRITE_ACK : WRITE_RECV;
            busy <= 1'b1;
            write_bursts <= write_bursts + 1;
          end
        READ_WAIT:
          if (wait_cnt == '0) state <= READ_SEND;
          else wait_cnt <= wait_cnt - 1'b1;
        READ_SEND:
          if (idx == (OFFSET_BITS+1)'(N)) begin
            state <= IDLE;
            busy <= 1'b0;
          end else begin
            mem2cache_msg <= MEM_SENT;
            mem2cache_address <= rd_addr;
            mem2cache_data <= ram[rd_addr[MEM_DEPTH_BITS-1:0]];
            idx <= idx + 1'b1;
          end
        WRITE_RECV:
          if (cache2mem_msg == WB_REQ) begin
            last_addr <= cache2mem_address;
            idx <= idx + 1'b1;
            if (idx == (OFFSET_BITS+1)'(N - 1)) state <= WRITE_ACK;
          end
        WRITE_ACK: begin
          mem2cache_msg <= MEM_READY;
          mem2cache_address <= last_addr;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
`ifndef SYNTHESIS
  // simulation-only activity report
  always_ff @(posedge clock)
    if (report) $display("memory_responder: read bursts=%0d write bursts=%0d cycles=%0d", read_bursts, write_bursts, cycles);
`endif
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed self-checking bench for memory_responder
module tb_memory_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic report = 1'b0;
  logic [3:0] c_msg = '0;
  logic [19:0] c_addr = '0;
  logic [31:0] c_data = '0;
  logic [3:0] m_msg;
  logic [19:0] m_addr;
  logic [31:0] m_data;
  logic busy;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  memory_responder dut (
    .clock(clock),
    .reset(reset),
    .cache2mem_msg(c_msg),
    .cache2mem_address(c_addr),
    .cache2mem_data(c_data),
    .mem2cache_msg(m_msg),
    .mem2cache_address(m_addr),
    .mem2cache_data(m_data),
    .busy(busy),
    .report(report)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic [3:0] m, input logic [19:0] a, input logic [31:0] d);
    c_msg = m;
    c_addr = a;
    c_data = d;
  endtask
  task automatic wb_burst(input logic [19:0] base, input logic [31:0] d0, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      drive(4'd2, base + 20'(i), d0 + 32'(i));
      tick;
      if (gaps && (i == 2 || i == 5)) begin
        drive(4'd0, '0, '0);
        repeat (2) begin
          tick;
          check("wb_gap_msg", 32'(m_msg), 32'd0);
          check("wb_gap_busy", 32'(busy), 32'd1);
        end
      end
    end
    drive(4'd0, '0, '0);
    check("wb_last_msg", 32'(m_msg), 32'd0);
    check("wb_last_busy", 32'(busy), 32'd1);
    tick;
    check("wb_ack_msg", 32'(m_msg), 32'd4);
    check("wb_ack_addr", 32'(m_addr), 32'(base + 20'd7));
    check("wb_ack_data", m_data, 32'd0);
    tick;
    check("wb_done_msg", 32'(m_msg), 32'd0);
    check("wb_done_busy", 32'(busy), 32'd0);
    check("wb_done_addr", 32'(m_addr), 32'd0);
  endtask
  task automatic rd_burst(input logic [19:0] a, input logic [19:0] base, input logic [31:0] d0, input bit interfere);
    drive(4'd1, a, '0);
    tick;
    drive(4'd0, '0, '0);
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (k < 4) begin
        check("rd_wait_msg", 32'(m_msg), 32'd0);
        check("rd_wait_busy", 32'(busy), 32'd1);
      end else if (k < 12) begin
        check("rd_msg", 32'(m_msg), 32'd3);
        check("rd_addr", 32'(m_addr), 32'(base + 20'(k - 4)));
        check("rd_data", m_data, d0 + 32'(k - 4));
      end else begin
        check("rd_end_msg", 32'(m_msg), 32'd0);
        check("rd_end_busy", 32'(busy), 32'd0);
        check("rd_end_addr", 32'(m_addr), 32'd0);
        check("rd_end_data", m_data, 32'd0);
      end
      if (interfere && k == 1) drive(4'd2, base, 32'hDEAD_BEEF);
      else if (interfere && k == 5) drive(4'd1, 20'h00100, '0);
      else drive(4'd0, '0, '0);
    end
  endtask
  initial begin
    drive(4'd1, 20'h00043, '0);
    repeat (2) tick;
    check("rst_msg", 32'(m_msg), 32'd0);
    check("rst_addr", 32'(m_addr), 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    drive(4'd0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("post_rst_msg", 32'(m_msg), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    wb_burst(20'h00040, 32'hA0, 1'b0);
    rd_burst(20'h00043, 20'h00040, 32'hA0, 1'b0);
    rd_burst(20'h00040, 20'h00040, 32'hA0, 1'b1);
    rd_burst(20'h00045, 20'h00040, 32'hA0, 1'b0);
    wb_burst(20'h00080, 32'hB0, 1'b1);
    rd_burst(20'h00087, 20'h00080, 32'hB0, 1'b0);
    wb_burst(20'h01040, 32'hC0, 1'b0);
    rd_burst(20'h00040, 20'h00040, 32'hC0, 1'b0);
    drive(4'd1, 20'h00040, '0);
    tick;
    drive(4'd0, '0, '0);
    repeat (7) tick;
    check("abort_w3_msg", 32'(m_msg), 32'd3);
    check("abort_w3_addr", 32'(m_addr), 32'h00043);
    check("abort_w3_data", m_data, 32'hC3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_msg", 32'(m_msg), 32'd0);
    check("abort_addr", 32'(m_addr), 32'd0);
    check("abort_data", m_data, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("abort_idle_msg", 32'(m_msg), 32'd0);
      check("abort_idle_busy", 32'(busy), 32'd0);
    end
    rd_burst(20'h00047, 20'h00040, 32'hC0, 1'b0);
    report = 1'b1;
    tick;
    report = 1'b0;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side end of the Cache2Memory message interface: receives cache2mem_* requests from a direct-mapped L1 cache and returns mem2cache_* responses.
- Serves line fills (read bursts) from an internal word-addressed RAM after a fixed latency.
- Absorbs line writebacks (write bursts) and acknowledges them.
- Sits between a cache and the simulated main memory in the core tile.

Parameters:
- DATA_WIDTH, 32, data word width.
- OFFSET_BITS, 3, log2 of words per line; N = 2^OFFSET_BITS.
- ADDRESS_BITS, 20, word address width.
- MSG_BITS, 4, message field width.
- MEM_DEPTH_BITS, 12, log2 of RAM words; RAM index = address[MEM_DEPTH_BITS-1:0] (higher bits alias).
- LATENCY, 4, cycles from R_REQ accept to first data word; legal range >= 1.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- cache2mem_msg  in  MSG_BITS  request message.
- cache2mem_address  in  ADDRESS_BITS  request word address.
- cache2mem_data  in  DATA_WIDTH  writeback data word.
- mem2cache_msg  out  MSG_BITS  response message.
- mem2cache_address  out  ADDRESS_BITS  response word address.
- mem2cache_data  out  DATA_WIDTH  response data word.
- busy  out  1  high when the FSM is not in IDLE.
- report  in  1  when high, print (simulation only) read-burst count, write-burst count, and cycle count.

Behaviour:
- Message codes: NO_REQ=0, R_REQ=1, WB_REQ=2, MEM_SENT=3, MEM_READY=4. All other codes are treated as NO_REQ.
- Reset:
  - Clears mem2cache_msg, mem2cache_address, mem2cache_data, busy, the counters, and the word index.
  - FSM goes to IDLE. RAM contents are not cleared.
  - Reset asserted mid-burst aborts the burst immediately. Outputs read 0 in the cycle after the reset edge.
  - Words already written before the abort stay in RAM.
- All outputs are registered.
- FSM states: IDLE, READ_WAIT, READ_SEND, WRITE_RECV, WRITE_ACK.
- IDLE:
  - Sampling R_REQ: latch base = address with low OFFSET_BITS bits forced to 0, then go to READ_WAIT (LATENCY=1 goes directly to READ_SEND).
  - Sampling WB_REQ: write data to RAM[address], set count=1, go to WRITE_RECV (N=1 goes directly to WRITE_ACK).
  - NO_REQ: stay in IDLE.
- READ_WAIT: count down LATENCY-1 cycles, then go to READ_SEND.
- READ_SEND:
  - Burst timing: R_REQ sampled at edge t gives mem2cache_msg=MEM_SENT in cycles t+LATENCY .. t+LATENCY+N-1.
  - Word i (0..N-1) carries mem2cache_address = base+i and mem2cache_data = RAM[base+i].
  - The cycle after word N-1, msg returns to NO_REQ and the FSM is in IDLE.
- WRITE_RECV:
  - Each sampled WB_REQ writes cache2mem_data to RAM[cache2mem_address] and increments count.
  - Cycles without WB_REQ stall the burst with no write and no count change.
  - When count reaches N, go to WRITE_ACK.
- WRITE_ACK:
  - mem2cache_msg=MEM_READY for exactly one cycle, with mem2cache_address = the last written address and data=0.
  - Then go to IDLE. A new request is accepted from the following cycle.
- Requests arriving while the FSM is not in IDLE, other than WB_REQ in WRITE_RECV, are ignored. A single outstanding request is guaranteed by the cache.
- Outside MEM_SENT and MEM_READY cycles, mem2cache_address and mem2cache_data are 0.
- Address arithmetic: base+i is computed modulo 2^ADDRESS_BITS. A burst never crosses a line boundary.
- Read-after-write: a read issued after MEM_READY returns the newly written data.

Test Plan:
- Assert reset for 2 cycles -> msg=0, address=0, data=0, busy=0. Hold R_REQ during reset -> no response after release.
- WB_REQ burst of 8 words to 0x00040..0x00047 with data 0xA0..0xA7 on consecutive cycles -> MEM_READY with address 0x00047 one cycle after the last word, then NO_REQ.
- R_REQ address 0x00043 (LATENCY=4) sampled at edge t -> MEM_SENT in cycles t+4..t+11 with addresses 0x00040..0x00047 and data 0xA0..0xA7. busy=0 at t+12.
- Writeback with 2-cycle NO_REQ gaps after words 2 and 5 -> all 8 words written, MEM_READY only after the 8th word. A read-back matches.
- R_REQ issued during READ_SEND, and WB_REQ issued during READ_WAIT -> both ignored. The burst completes unchanged and RAM is not modified.
- Aliasing: write line 0x01040 (MEM_DEPTH_BITS=12), then read 0x00040 -> same data. Reset at burst word 3 -> outputs 0 next cycle, FSM in IDLE. The next R_REQ is served normally.
